// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family: FSM state encoding
// and the beat-counter width helper.
package shift_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_t;

  function automatic int unsigned cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_beat_counter.sv
// Loadable down-counter tracking the remaining beats of a frame.
// Load has priority over decrement. The zero flag marks the final beat.
module shift_beat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/piso_shift_right_5bit.sv
// Parallel-in, serial-out right shifter: drains a loaded word LSB-first
// over a valid/ready serial port, with FILL entering at the MSB.
module piso_shift_right_5bit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter logic        FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [WIDTH-1:0] Q,
  output logic             busy
);

  localparam int unsigned        CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH - 1);

  shift_state_t     r_state;
  shift_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] w_cnt;
  logic             w_zero;
  logic             w_accept;
  logic             w_beat;
  logic             w_in_shift;

  assign w_in_shift = (r_state == ST_SHIFT);
  assign ser_valid  = w_in_shift;
  assign ser_out    = w_in_shift & r_q[0];
  assign ser_last   = w_in_shift & w_zero;
  assign busy       = w_in_shift;
  assign Q          = r_q;

  // Ready looks through ser_ready so a new word can land on the final beat.
  assign load_ready = !w_in_shift || (ser_last && ser_ready);
  assign w_accept   = load_valid && load_ready;
  assign w_beat     = ser_valid && ser_ready;

  shift_beat_counter #(
    .W (CNT_W)
  ) u_beat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_accept),
    .dec      (w_beat && (w_cnt != '0)),
    .load_val (CNT_INIT),
    .count    (w_cnt),
    .zero     (w_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_beat && w_zero && !w_accept) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (w_accept) begin
      r_q <= load_data;
    end else if (w_beat) begin
      r_q <= {FILL, r_q[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_piso_shift_right_5bit.sv
// Directed bench for piso_shift_right_5bit with a bit-level scoreboard
// plus a FILL=1 instance for the thermometer-fill case.
module tb_piso_shift_right_5bit;

  localparam int unsigned W = 5;

  typedef struct {
    logic b;
    logic last;
  } exp_bit_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid, load_ready, ser_out, ser_valid, ser_ready, ser_last, busy;
  logic [W-1:0] load_data, q;

  logic         f_load_valid, f_load_ready, f_ser_out, f_ser_valid, f_ser_ready, f_ser_last, f_busy;
  logic [W-1:0] f_load_data, f_q;

  exp_bit_t     sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  piso_shift_right_5bit #(.WIDTH(W), .FILL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .ser_last(ser_last), .Q(q), .busy(busy)
  );

  piso_shift_right_5bit #(.WIDTH(W), .FILL(1'b1)) dut_fill (
    .clk(clk), .rst_n(rst_n), .load_valid(f_load_valid), .load_ready(f_load_ready),
    .load_data(f_load_data), .ser_out(f_ser_out), .ser_valid(f_ser_valid),
    .ser_ready(f_ser_ready), .ser_last(f_ser_last), .Q(f_q), .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the serial port against the scoreboard, then advances one edge.
  task automatic step();
    logic     exp_ready;
    exp_bit_t e;
    #1;
    exp_ready = (sb.size() == 0) || (sb.size() == 1 && ser_ready);
    chk("ser_valid", {31'd0, ser_valid}, {31'd0, sb.size() != 0});
    chk("busy", {31'd0, busy}, {31'd0, sb.size() != 0});
    chk("load_ready", {31'd0, load_ready}, {31'd0, exp_ready});
    if (sb.size() != 0) begin
      chk("ser_out", {31'd0, ser_out}, {31'd0, sb[0].b});
      chk("ser_last", {31'd0, ser_last}, {31'd0, sb[0].last});
      if (ser_ready) e = sb.pop_front();
    end else begin
      chk("ser_out_idle", {31'd0, ser_out}, 32'd0);
      chk("ser_last_idle", {31'd0, ser_last}, 32'd0);
    end
    if (load_valid && exp_ready) begin
      for (int unsigned i = 0; i < W; i++) begin
        e.b    = load_data[i];
        e.last = (i == W - 1);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    step();
    load_valid = 1'b0;
    chk("q_after_load", {27'd0, q}, {27'd0, d});
  endtask

  initial begin
    logic [W-1:0] exp_q[5];

    rst_n = 1'b0;
    load_valid = 1'b0; load_data = '0; ser_ready = 1'b1;
    f_load_valid = 1'b0; f_load_data = '0; f_ser_ready = 1'b1;
    #1;
    chk("rst_q", {27'd0, q}, 32'd0);
    chk("rst_valid", {31'd0, ser_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    step();

    // Single frame, ser_ready held high
    exp_q[0] = 5'b01011; exp_q[1] = 5'b00101; exp_q[2] = 5'b00010;
    exp_q[3] = 5'b00001; exp_q[4] = 5'b00000;
    load_word(5'b10110);
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      chk("q_shift", {27'd0, q}, {27'd0, exp_q[i]});
    end
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Back-pressure after two bits
    load_word(5'b10110);
    step(); step();
    ser_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk("q_hold", {27'd0, q}, 32'b00101);
    end
    ser_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) step();

    // Back-to-back frames; second word offered during the last bit
    load_word(5'b10110);
    for (int unsigned i = 0; i < 4; i++) step();
    load_valid = 1'b1;
    load_data  = 5'b00011;
    #1;
    chk("b2b_last", {31'd0, ser_last}, 32'd1);
    chk("b2b_ready", {31'd0, load_ready}, 32'd1);
    step();
    load_valid = 1'b0;
    chk("b2b_q", {27'd0, q}, 32'b00011);
    for (int unsigned i = 0; i < 6; i++) step();

    // Load attempt mid-frame is refused
    load_word(5'b10110);
    step(); step();
    load_valid = 1'b1;
    load_data  = 5'b11111;
    step();
    load_valid = 1'b0;
    chk("ignored_q", {27'd0, q}, 32'b00010);
    for (int unsigned i = 0; i < 3; i++) step();

    // Asynchronous reset mid-frame
    load_word(5'b10110);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_q", {27'd0, q}, 32'd0);
    chk("arst_valid", {31'd0, ser_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 4; i++) step();

    // FILL=1 thermometer fill
    exp_q[0] = 5'b10000; exp_q[1] = 5'b11000; exp_q[2] = 5'b11100;
    exp_q[3] = 5'b11110; exp_q[4] = 5'b11111;
    f_load_valid = 1'b1;
    f_load_data  = 5'b00000;
    step();
    f_load_valid = 1'b0;
    chk("fill_valid", {31'd0, f_ser_valid}, 32'd1);
    for (int unsigned i = 0; i < 5; i++) begin
      chk("fill_ser_out", {31'd0, f_ser_out}, 32'd0);
      chk("fill_last", {31'd0, f_ser_last}, {31'd0, i == 4});
      step();
      chk("fill_q", {27'd0, f_q}, {27'd0, exp_q[i]});
    end
    chk("fill_idle", {31'd0, f_busy}, 32'd0);
    chk("fill_ready", {31'd0, f_load_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
